// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
// DIV_WIDTH   : default operand/result width.
// div_state_e : controller states (IDLE, BUSY, DONE).
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step, purely combinational.
// Ports:
//   divisor  : unsigned divisor
//   rem_in   : partial remainder before the step
//   dvd_in   : dividend shift register (MSB is the next bit to bring in)
//   quo_in   : quotient shift register before the step
//   rem_out  : partial remainder after the step
//   dvd_out  : dividend shift register advanced by one bit
//   quo_out  : quotient with the new bit shifted in at the LSB
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] divisor,
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] dvd_in,
    input  logic [WIDTH-1:0] quo_in,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] dvd_out,
    output logic [WIDTH-1:0] quo_out
);

    logic        [WIDTH:0]   shifted;
    logic signed [WIDTH+1:0] diff;
    logic                    q_bit;

    // The shifted remainder needs WIDTH+1 bits; one more bit holds the
    // sign of the trial subtraction.
    assign shifted = {rem_in, dvd_in[WIDTH-1]};
    assign diff    = $signed({1'b0, shifted}) - $signed({2'b00, divisor});
    assign q_bit   = ~diff[WIDTH+1];

    // A kept difference is always below the divisor, so it fits in WIDTH bits.
    assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign dvd_out = {dvd_in[WIDTH-2:0], 1'b0};
    assign quo_out = {quo_in[WIDTH-2:0], q_bit};

endmodule

// File: rtl/div_iterative.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   valid_in / ready_out  : operand handshake (accepts only in IDLE)
//   dividend, divisor     : unsigned operands, sampled at acceptance
//   valid_out / ready_in  : result handshake (result held in DONE)
//   quotient, remainder   : registered results, kept until the next result
// Divide-by-zero needs no special case: every trial subtraction succeeds,
// giving quotient = all ones and remainder = dividend.
module div_iterative
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int                CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_e        state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  rem_r, dvd_r, quo_r, dsr_r;
    logic [WIDTH-1:0]  rem_nx, dvd_nx, quo_nx;
    logic              accept, last_step;

    assign accept    = valid_in && (state == IDLE);
    assign last_step = (state == BUSY) && (cnt == LAST_STEP);

    div_step #(.WIDTH(WIDTH)) u_step (
        .divisor (dsr_r),
        .rem_in  (rem_r),
        .dvd_in  (dvd_r),
        .quo_in  (quo_r),
        .rem_out (rem_nx),
        .dvd_out (dvd_nx),
        .quo_out (quo_nx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready_out  = 1'b0;
        valid_out  = 1'b0;
        case (state)
            IDLE: begin
                ready_out = 1'b1;
                if (valid_in) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt == LAST_STEP) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                valid_out = 1'b1;
                if (ready_in) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Working registers advance one step per BUSY cycle; the result
    // registers are written only on the final step so they keep the
    // previous answer through IDLE and the next computation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            rem_r     <= '0;
            dvd_r     <= '0;
            quo_r     <= '0;
            dsr_r     <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (accept) begin
            cnt   <= '0;
            rem_r <= '0;
            quo_r <= '0;
            dvd_r <= dividend;
            dsr_r <= divisor;
        end else if (state == BUSY) begin
            cnt   <= cnt + 1'b1;
            rem_r <= rem_nx;
            dvd_r <= dvd_nx;
            quo_r <= quo_nx;
            if (last_step) begin
                quotient  <= quo_nx;
                remainder <= rem_nx;
            end
        end
    end

endmodule

// File: tb/tb_div_iterative.sv
module tb_div_iterative;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_in;
    logic         ready_out;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         valid_out;
    logic         ready_in;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_iterative #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .dividend  (dividend),
        .divisor   (divisor),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .quotient  (quotient),
        .remainder (remainder)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, with the divide-by-zero convention.
    function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? {W{1'b1}} : a / b;
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? a : a % b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        check("ready_before_accept", {31'b0, ready_out}, 1);
        dividend = a;
        divisor  = b;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        check("ready_low_busy", {31'b0, ready_out}, 0);
    endtask

    task automatic wait_done(input bit scramble, output int lat);
        lat = 0;
        while (valid_out !== 1'b1 && lat < 200) begin
            if (scramble) begin
                dividend = $urandom;
                divisor  = $urandom;
                valid_in = 1'($urandom_range(0, 1));
            end
            tick();
            lat++;
        end
        valid_in = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit scramble, input int hold);
        int lat;
        logic [W-1:0] eq, er;
        eq = ref_q(a, b);
        er = ref_r(a, b);
        ready_in = 1'b0;
        start_op(a, b);
        wait_done(scramble, lat);
        check("latency", W'(lat), W);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", {31'b0, valid_out}, 1);
            check("hold_quotient", quotient, eq);
            check("hold_remainder", remainder, er);
        end
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        check("valid_drop", {31'b0, valid_out}, 0);
        check("ready_back", {31'b0, ready_out}, 1);
        check("retain_quotient", quotient, eq);
        check("retain_remainder", remainder, er);
    endtask

    initial begin
        int lat;
        bit saw;
        logic [W-1:0] a, b;

        rst      = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check("rst_ready", {31'b0, ready_out}, 1);
        check("rst_valid", {31'b0, valid_out}, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        @(negedge clk);
        rst = 1'b0;

        // First acceptance on the first edge after reset release, with backpressure.
        run_op(32'd13, 32'd3, 1'b0, 10);
        run_op(32'd100, 32'd7, 1'b0, 0);
        run_op(32'd5, 32'd9, 1'b0, 1);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        run_op(32'h1234_5678, 32'd0, 1'b0, 2);
        // Operands and valid_in wiggled throughout BUSY/DONE must not matter.
        run_op(32'd1000, 32'd33, 1'b1, 3);

        // ready_in already high when DONE is entered: one-cycle valid.
        ready_in = 1'b1;
        start_op(32'd77, 32'd5);
        wait_done(1'b0, lat);
        check("fast_latency", W'(lat), W);
        check("fast_quotient", quotient, 32'd15);
        check("fast_remainder", remainder, 32'd2);
        tick();
        check("fast_valid_one_cycle", {31'b0, valid_out}, 0);
        check("fast_ready_back", {31'b0, ready_out}, 1);
        ready_in = 1'b0;

        // Reset during BUSY at step 10 aborts the operation.
        start_op(32'd13, 32'd3);
        repeat (9) tick();
        rst = 1'b1;
        #1;
        check("abort_ready", {31'b0, ready_out}, 1);
        check("abort_valid", {31'b0, valid_out}, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        #3;
        rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid_out === 1'b1) saw = 1'b1;
        end
        check("abort_no_result", {31'b0, saw}, 0);
        run_op(32'd100, 32'd7, 1'b0, 0);

        // Randomized operands, including small and zero divisors.
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            case (i % 4)
                0:       b = $urandom;
                1:       b = W'($urandom_range(1, 255));
                2:       b = '0;
                default: b = a >> $urandom_range(0, 31);
            endcase
            run_op(a, b, (i % 3) == 0, i % 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
